// File: rtl/bram_sdp_param.sv
// -----------------------------------------------------------------------------
// bram_sdp_param
//
// Simple-dual-port block RAM (one read port, one write port, one clock) with:
//   - byte-lane write enables
//   - write-first forwarding on a same-cycle read/write address collision,
//     merged per byte in fabric so it never relies on RAM collision modes
//   - optional output pipeline register (OUT_REG)
//   - hardware clear engine that fills every entry with CLEAR_VALUE after
//     reset (CLEAR_ON_RESET) or on clr_req
//
// Ports:
//   clk      rising-edge clock for all logic
//   reset    synchronous, active-high reset
//   raddr    read address
//   rden     read request, accepted only while ready=1
//   rdata    read data, holds its value between accepted reads
//   rvalid   one-cycle pulse when rdata updates for an accepted read
//   waddr    write address
//   wen      per-byte write enables, lane i = bits [i*BYTE_W +: BYTE_W]
//   wdata    write data
//   clr_req  single-cycle request to clear the whole array
//   ready    1 = idle and user ports active, 0 = clear sweep in progress
// -----------------------------------------------------------------------------
module bram_sdp_param #(
  parameter int                 DATA_W         = 32,
  parameter int                 ADDR_W         = 10,
  parameter int                 BYTE_W         = 8,
  parameter int                 OUT_REG        = 0,
  parameter int                 CLEAR_ON_RESET = 1,
  parameter logic [DATA_W-1:0]  CLEAR_VALUE    = '0
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [ADDR_W-1:0]          raddr,
  input  logic                       rden,
  output logic [DATA_W-1:0]          rdata,
  output logic                       rvalid,
  input  logic [ADDR_W-1:0]          waddr,
  input  logic [DATA_W/BYTE_W-1:0]   wen,
  input  logic [DATA_W-1:0]          wdata,
  input  logic                       clr_req,
  output logic                       ready
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam int NBE   = DATA_W / BYTE_W;

  typedef enum logic {ST_IDLE, ST_CLEAR} state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   clr_cnt_q, clr_cnt_d;
  logic                ready_q, ready_d;

  // Read pipeline: stage 1 is the RAM read register plus the captured
  // forwarding lanes; stage 2 is the optional output register.
  logic [DATA_W-1:0]   ram_rd_q;
  logic [NBE-1:0]      fwd_mask_q, fwd_mask_d;
  logic [DATA_W-1:0]   fwd_data_q, fwd_data_d;
  logic                vld1_q, vld1_d;
  logic [DATA_W-1:0]   out_q, out_d;
  logic                vld2_q, vld2_d;
  logic [DATA_W-1:0]   merged;

  // Physical RAM write port, shared by user writes and the clear sweep.
  logic [NBE-1:0]      mem_we;
  logic [ADDR_W-1:0]   mem_waddr;
  logic [DATA_W-1:0]   mem_wdata;

  logic [DATA_W-1:0]   mem [DEPTH];

  logic                rd_acc;

  // ready_q mirrors state_q, so no combinational path exists from clr_req.
  assign rd_acc = rden & ready_q;
  assign ready  = ready_q;

  // ---------------------------------------------------------------------------
  // Clear FSM
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal gets a default before any branch, so no path leaves
    // it unassigned and no latch is inferred.
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    unique case (state_q)
      ST_IDLE: begin
        if (clr_req) state_d = ST_CLEAR;
      end
      ST_CLEAR: begin
        // Counter wraps to 0 naturally on the last entry.
        clr_cnt_d = clr_cnt_q + ADDR_W'(1);
        if (&clr_cnt_q) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    ready_d = (state_d == ST_IDLE);
  end

  // ---------------------------------------------------------------------------
  // RAM write port mux: the sweep owns the port while clearing; nothing is
  // written while reset is held so an aborted sweep restarts cleanly.
  // ---------------------------------------------------------------------------
  always_comb begin
    mem_we    = '0;
    mem_waddr = waddr;
    mem_wdata = wdata;
    if (!reset) begin
      if (state_q == ST_CLEAR) begin
        mem_we    = '1;
        mem_waddr = clr_cnt_q;
        mem_wdata = CLEAR_VALUE;
      end else begin
        mem_we    = wen;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Read pipeline next-state and write-first merge
  // ---------------------------------------------------------------------------
  always_comb begin
    fwd_mask_d = fwd_mask_q;
    fwd_data_d = fwd_data_q;
    if (rd_acc) begin
      // The RAM returns old data on a collision; remember which lanes the
      // concurrent write touched so they can be replaced at the output.
      fwd_mask_d = (raddr == waddr) ? wen : '0;
      fwd_data_d = wdata;
    end
    vld1_d = rd_acc;
  end

  always_comb begin
    merged = ram_rd_q;
    for (int i = 0; i < NBE; i++) begin
      if (fwd_mask_q[i]) merged[i*BYTE_W +: BYTE_W] = fwd_data_q[i*BYTE_W +: BYTE_W];
    end
  end

  always_comb begin
    out_d  = vld1_q ? merged : out_q;
    vld2_d = vld1_q;
  end

  assign rdata  = (OUT_REG != 0) ? out_q  : merged;
  assign rvalid = (OUT_REG != 0) ? vld2_q : vld1_q;

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  // NOTE: state is updated with non-blocking assignments so every flop samples
  // the values from before the edge, independent of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_IDLE;
      ready_q    <= (CLEAR_ON_RESET == 0);
      clr_cnt_q  <= '0;
      fwd_mask_q <= '0;
      fwd_data_q <= '0;
      vld1_q     <= 1'b0;
      out_q      <= '0;
      vld2_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      ready_q    <= ready_d;
      clr_cnt_q  <= clr_cnt_d;
      fwd_mask_q <= fwd_mask_d;
      fwd_data_q <= fwd_data_d;
      vld1_q     <= vld1_d;
      out_q      <= out_d;
      vld2_q     <= vld2_d;
    end
  end

  // RAM read register: synchronous read with a sync reset, which block RAM
  // output latches support, so rdata comes out of reset as zero.
  always_ff @(posedge clk) begin
    if (reset) begin
      ram_rd_q <= '0;
    end else if (rd_acc) begin
      ram_rd_q <= mem[raddr];
    end
  end

  // NOTE: the array itself has no reset; clearing is done by the sweep, which
  // keeps this mappable onto block RAM.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NBE; i++) begin
      if (mem_we[i]) mem[mem_waddr][i*BYTE_W +: BYTE_W] <= mem_wdata[i*BYTE_W +: BYTE_W];
    end
  end

endmodule

// File: tb/tb_bram_sdp_param.sv
// -----------------------------------------------------------------------------
// tb_bram_sdp_param
//
// Drives two instances (OUT_REG=0 and OUT_REG=1, 16 entries) with identical
// stimulus. The stimulus task keeps a byte-lane reference model of the array
// and of the clear sweep, and pushes the expected read data into one
// scoreboard queue per instance. A monitor pops and compares whenever an
// instance raises rvalid, and also checks read latency and that rdata holds.
// -----------------------------------------------------------------------------
module tb_bram_sdp_param;

  localparam int AW    = 4;
  localparam int DW    = 32;
  localparam int NB    = 4;
  localparam int DEPTH = 16;
  localparam logic [DW-1:0] CLR_V = 32'h0000_0000;

  logic          clk = 1'b0;
  logic          reset;
  logic [AW-1:0] raddr, waddr;
  logic          rden, clr_req;
  logic [NB-1:0] wen;
  logic [DW-1:0] wdata;
  logic [DW-1:0] rdata0, rdata1;
  logic          rvalid0, rvalid1, ready0, ready1;

  always #5 clk = ~clk;

  bram_sdp_param #(
    .DATA_W(DW), .ADDR_W(AW), .BYTE_W(8), .OUT_REG(0),
    .CLEAR_ON_RESET(1), .CLEAR_VALUE(CLR_V)
  ) u_dut0 (
    .clk(clk), .reset(reset), .raddr(raddr), .rden(rden), .rdata(rdata0),
    .rvalid(rvalid0), .waddr(waddr), .wen(wen), .wdata(wdata),
    .clr_req(clr_req), .ready(ready0)
  );

  bram_sdp_param #(
    .DATA_W(DW), .ADDR_W(AW), .BYTE_W(8), .OUT_REG(1),
    .CLEAR_ON_RESET(1), .CLEAR_VALUE(CLR_V)
  ) u_dut1 (
    .clk(clk), .reset(reset), .raddr(raddr), .rden(rden), .rdata(rdata1),
    .rvalid(rvalid1), .waddr(waddr), .wen(wen), .wdata(wdata),
    .clr_req(clr_req), .ready(ready1)
  );

  typedef struct {
    logic [DW-1:0] data;
    int            tag;
  } exp_t;

  exp_t          sb0[$];
  exp_t          sb1[$];
  int            checks   = 0;
  int            failures = 0;
  int            cyc      = 0;
  logic [DW-1:0] model [DEPTH];
  bit            mdl_clear = 1'b0;
  int            mdl_cnt   = 0;
  logic [DW-1:0] exp_last [2];
  bit            started = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One clock of stimulus, called at a falling edge. Updates the reference
  // model exactly as the array should behave at the coming rising edge.
  task automatic step(input logic rd, input logic [AW-1:0] ra, input logic [NB-1:0] we,
                      input logic [AW-1:0] wa, input logic [DW-1:0] wd, input logic clr);
    exp_t          e;
    logic [DW-1:0] ex;
    check("dut0_ready", ready0, !mdl_clear);
    check("dut1_ready", ready1, !mdl_clear);
    rden = rd; raddr = ra; wen = we; waddr = wa; wdata = wd; clr_req = clr;
    if (mdl_clear) begin
      model[mdl_cnt] = CLR_V;
      mdl_cnt++;
      if (mdl_cnt == DEPTH) begin
        mdl_clear = 1'b0;
        mdl_cnt   = 0;
      end
    end else begin
      if (rd) begin
        ex = model[ra];
        if (wa == ra) begin
          for (int i = 0; i < NB; i++) if (we[i]) ex[i*8 +: 8] = wd[i*8 +: 8];
        end
        e.data = ex;
        e.tag  = cyc;
        sb0.push_back(e);
        sb1.push_back(e);
      end
      for (int i = 0; i < NB; i++) if (we[i]) model[wa][i*8 +: 8] = wd[i*8 +: 8];
      if (clr) begin
        mdl_clear = 1'b1;
        mdl_cnt   = 0;
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset(input int n);
    reset = 1'b1; rden = 1'b0; wen = '0; clr_req = 1'b0;
    raddr = '0; waddr = '0; wdata = '0;
    @(posedge clk);
    sb0.delete();
    sb1.delete();
    exp_last[0] = '0;
    exp_last[1] = '0;
    repeat (n - 1) @(posedge clk);
    @(negedge clk);
    reset     = 1'b0;
    started   = 1'b1;
    mdl_clear = 1'b1;
    mdl_cnt   = 0;
    check("dut0_reset_rdata",  rdata0,  '0);
    check("dut0_reset_rvalid", rvalid0, '0);
    check("dut1_reset_rdata",  rdata1,  '0);
    check("dut1_reset_rvalid", rvalid1, '0);
  endtask

  task automatic mon_port(input int id, input logic rv, input logic [DW-1:0] rd, input int lat);
    exp_t e;
    bit   have;
    if (id == 0) have = (sb0.size() > 0);
    else         have = (sb1.size() > 0);
    if (have) begin
      if (id == 0) e = sb0[0];
      else         e = sb1[0];
    end
    if (rv) begin
      check($sformatf("dut%0d_rvalid_expected", id), have, 1);
      if (have) begin
        if (id == 0) void'(sb0.pop_front());
        else         void'(sb1.pop_front());
        check($sformatf("dut%0d_rdata", id), rd, e.data);
        check($sformatf("dut%0d_latency", id), 32'(cyc - e.tag), 32'(lat));
        exp_last[id] = e.data;
      end
    end else begin
      check($sformatf("dut%0d_rdata_hold", id), rd, exp_last[id]);
      if (have && (cyc - e.tag > lat)) begin
        check($sformatf("dut%0d_rvalid_timeout", id), rv, 1);
        if (id == 0) void'(sb0.pop_front());
        else         void'(sb1.pop_front());
      end
    end
  endtask

  always @(negedge clk) begin
    if (started && !reset) begin
      mon_port(0, rvalid0, rdata0, 1);
      mon_port(1, rvalid1, rdata1, 2);
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [AW-1:0] ra, wa;
    reset = 1'b1; rden = 1'b0; wen = '0; clr_req = 1'b0;
    raddr = '0; waddr = '0; wdata = '0;
    @(negedge clk);
    do_reset(3);

    // Post-reset sweep: 16 cycles with ready low; reads are ignored.
    for (int i = 0; i < DEPTH; i++) step(1'b1, AW'(i), '0, '0, '0, 1'b0);
    // Every entry reads the clear value.
    for (int i = 0; i < DEPTH; i++) step(1'b1, AW'(i), '0, '0, '0, 1'b0);

    // Plain write then read of the same address on the next cycle.
    step(1'b0, '0, 4'b1111, 4'd5, 32'hDEAD_BEEF, 1'b0);
    step(1'b1, 4'd5, '0, '0, '0, 1'b0);
    step(1'b0, '0, '0, '0, '0, 1'b0);

    // Collision merge, then a later read of the merged entry.
    step(1'b0, '0, 4'b1111, 4'd9, 32'h1122_3344, 1'b0);
    step(1'b1, 4'd9, 4'b0101, 4'd9, 32'hAABB_CCDD, 1'b0);
    step(1'b0, '0, '0, '0, '0, 1'b0);
    step(1'b1, 4'd9, '0, '0, '0, 1'b0);

    // Mid-operation clear: fill, then clr_req with a read and a write.
    for (int i = 0; i < DEPTH; i++)
      step(1'b0, '0, 4'b1111, AW'(i), 32'(i + 1) * 32'h0101_0101, 1'b0);
    step(1'b1, 4'd3, 4'b0011, 4'd7, 32'hCAFE_F00D, 1'b1);
    for (int i = 0; i < DEPTH; i++)
      step(1'b1, AW'(i), 4'b1111, AW'(i), 32'hFFFF_FFFF, (i == 4));
    for (int i = 0; i < DEPTH; i++) step(1'b1, AW'(i), '0, '0, '0, 1'b0);

    // Reset at sweep counter 7; a clr_req during the restarted sweep is ignored.
    for (int i = 0; i < DEPTH; i++)
      step(1'b0, '0, 4'b1111, AW'(i), 32'h5A5A_0000 | 32'(i), 1'b0);
    step(1'b0, '0, '0, '0, '0, 1'b1);
    for (int i = 0; i < 7; i++) step(1'b0, '0, '0, '0, '0, (i == 3));
    do_reset(1);
    for (int i = 0; i < DEPTH; i++) step(1'b0, '0, '0, '0, '0, (i == 5));
    for (int i = 0; i < DEPTH; i++) step(1'b1, AW'(i), '0, '0, '0, 1'b0);

    // Random traffic without clears, collisions biased to occur often.
    for (int n = 0; n < 10000; n++) begin
      ra = AW'($urandom);
      wa = ($urandom_range(0, 1) == 1) ? ra : AW'($urandom);
      step(1'($urandom_range(0, 1)), ra, NB'($urandom), wa, $urandom, 1'b0);
    end

    for (int i = 0; i < 4; i++) step(1'b0, '0, '0, '0, '0, 1'b0);
    check("dut0_scoreboard_drained", 32'(sb0.size()), 0);
    check("dut1_scoreboard_drained", 32'(sb1.size()), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
